// File: rtl/dnn_hex_pkg.sv
// Shared constants and types for the HEX display writer: segment patterns,
// FSM state encoding and a constant helper for decimal range limits.
package dnn_hex_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    // Active-low segment patterns, bit0 = a .. bit6 = g
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // 10**n, evaluated at elaboration time for range limits
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/dnn_bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, exactly DATA_W clocks per conversion. Values that do not fit in
// NUM_DIGITS decimal digits raise the overflow flag.
module dnn_bin_to_bcd_seq
    import dnn_hex_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] BCD_MAX = DATA_W'(pow10(NUM_DIGITS) - 64'd1);

    logic [DATA_W-1:0] bin_reg;
    logic [BCD_W-1:0]  bcd_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic [BCD_W-1:0]  adjusted;

    // Add 3 to every BCD digit that is 5 or more before the next shift
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adjust
            assign adjusted[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                         (bcd_reg[4*gi +: 4] + 4'd3) :
                                          bcd_reg[4*gi +: 4];
        end
    endgenerate

    // Load on start, then shift one binary bit into the BCD register per clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_reg      <= '0;
            bcd_reg      <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (start) begin
            bin_reg      <= value;
            bcd_reg      <= '0;
            count_reg    <= CNT_W'(DATA_W);
            overflow_reg <= (value > BCD_MAX);
        end else if (busy) begin
            {bcd_reg, bin_reg} <= {adjusted, bin_reg} << 1;
            count_reg          <= count_reg - CNT_W'(1);
        end
    end

    assign busy     = (count_reg != '0);
    // High in the cycle whose closing edge performs the final shift, so the
    // consumer can move on exactly when the BCD result becomes valid.
    assign done     = (count_reg == CNT_W'(1));
    assign bcd      = bcd_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/dnn_accel_system_hex_writer.sv
// Avalon-MM master driving a row of HEX PIOs. Takes a value on a valid/ready
// handshake, optionally converts it to BCD, encodes each digit to 7-segment
// and writes only the digits whose pattern differs from what was last written.
module dnn_accel_system_hex_writer
    import dnn_hex_pkg::*;
#(
    parameter int                NUM_DIGITS   = 6,
    parameter int                DATA_W       = 24,   // must equal 4*NUM_DIGITS
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                DIGIT_STRIDE = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_decimal,
    input  logic              in_lzb,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest
);

    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    // Digit index one past the last digit marks the end of the WRITE sweep
    localparam logic [IDX_W-1:0] END_IDX = IDX_W'(NUM_DIGITS);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   value_reg, value_next;
    logic                decimal_reg, decimal_next;
    logic                lzb_reg, lzb_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [IDX_W-1:0]    bus_digit_reg, bus_digit_next;
    logic                cs_reg, cs_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [6:0]          seg_reg, seg_next;
    logic                in_ready_reg;

    logic [6:0]          shadow_reg [NUM_DIGITS];
    logic                shadow_valid_reg [NUM_DIGITS];

    logic                transfer;
    logic                bcd_start, bcd_busy, bcd_done, bcd_overflow;
    logic [4*NUM_DIGITS-1:0] bcd_digits;

    logic [3:0]          digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_from;
    logic [6:0]          pattern [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] changed;
    logic [6:0]          cur_pattern;
    logic                cur_changed;
    logic                write_done;

    // The converter is idle whenever we are in IDLE; the busy gate only
    // guards against starting a second conversion on top of a running one.
    assign transfer   = in_valid && in_ready_reg && !bcd_busy;
    assign bcd_start  = transfer && in_decimal;
    assign write_done = cs_reg && !avm_waitrequest;

    dnn_bin_to_bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (bcd_start),
        .value    (in_value),
        .busy     (bcd_busy),
        .done     (bcd_done),
        .bcd      (bcd_digits),
        .overflow (bcd_overflow)
    );

    // Per-digit source nibble, segment pattern and "needs writing" flag
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_val[gi] = decimal_reg ? bcd_digits[4*gi +: 4]
                                               : value_reg[4*gi +: 4];
            assign pattern[gi]   = (decimal_reg && bcd_overflow)           ? SEG_DASH  :
                                   (lzb_reg && (gi > 0) && zero_from[gi])  ? SEG_BLANK :
                                   SEG_LUT[digit_val[gi]];
            assign changed[gi]   = !shadow_valid_reg[gi] ||
                                   (shadow_reg[gi] != pattern[gi]);
        end
    endgenerate

    // zero_from[i]: digit i and every more significant digit are zero
    always_comb begin
        logic all_zero;
        zero_from = '0;
        all_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (digit_val[i] == 4'd0);
            zero_from[i] = all_zero;
        end
    end

    // Select the digit currently being visited by the WRITE sweep
    always_comb begin
        cur_pattern = SEG_BLANK;
        cur_changed = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_pattern = pattern[i];
                cur_changed = changed[i];
            end
        end
    end

    // Next-state and bus-register logic; the bus may only move on when idle
    // or when the current write is accepted (waitrequest low)
    always_comb begin
        state_next     = state_reg;
        value_next     = value_reg;
        decimal_next   = decimal_reg;
        lzb_next       = lzb_reg;
        idx_next       = idx_reg;
        bus_digit_next = bus_digit_reg;
        cs_next        = cs_reg;
        addr_next      = addr_reg;
        seg_next       = seg_reg;

        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    value_next   = in_value;
                    decimal_next = in_decimal;
                    lzb_next     = in_lzb;
                    idx_next     = '0;
                    state_next   = in_decimal ? CONVERT : WRITE;
                end
            end
            CONVERT: begin
                if (bcd_done) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!cs_reg || write_done) begin
                    if (idx_reg == END_IDX) begin
                        cs_next    = 1'b0;
                        state_next = IDLE;
                    end else begin
                        cs_next        = cur_changed;
                        bus_digit_next = idx_reg;
                        idx_next       = idx_reg + IDX_W'(1);
                        if (cur_changed) begin
                            addr_next = BASE_ADDR +
                                        ADDR_W'(idx_reg) * ADDR_W'(DIGIT_STRIDE);
                            seg_next  = cur_pattern;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cs_next    = 1'b0;
            end
        endcase
    end

    // State, captured request and bus output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            value_reg     <= '0;
            decimal_reg   <= 1'b0;
            lzb_reg       <= 1'b0;
            idx_reg       <= '0;
            bus_digit_reg <= '0;
            cs_reg        <= 1'b0;
            addr_reg      <= '0;
            seg_reg       <= '0;
            in_ready_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            value_reg     <= value_next;
            decimal_reg   <= decimal_next;
            lzb_reg       <= lzb_next;
            idx_reg       <= idx_next;
            bus_digit_reg <= bus_digit_next;
            cs_reg        <= cs_next;
            addr_reg      <= addr_next;
            seg_reg       <= seg_next;
            in_ready_reg  <= (state_next == IDLE);
        end
    end

    // Shadow copy of what each PIO holds; updated when its write is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_reg[i]       <= '0;
                shadow_valid_reg[i] <= 1'b0;
            end
        end else if (write_done) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus_digit_reg == IDX_W'(i)) begin
                    shadow_reg[i]       <= seg_reg;
                    shadow_valid_reg[i] <= 1'b1;
                end
            end
        end
    end

    assign in_ready       = in_ready_reg;
    assign avm_chipselect = cs_reg;
    assign avm_write_n    = !cs_reg;
    assign avm_address    = addr_reg;
    assign avm_writedata  = {25'b0, seg_reg};

endmodule

// File: tb/tb_dnn_accel_system_hex_writer.sv
// Bench for the HEX writer: directed scenarios followed by randomized
// updates, checked against a digit-level model of the display contents.
module tb_dnn_accel_system_hex_writer;

    localparam int N      = 6;
    localparam int DW     = 24;
    localparam int AW     = 16;
    localparam int STRIDE = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] in_value = '0;
    logic          in_decimal = 1'b0;
    logic          in_lzb = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [31:0]   avm_writedata;
    logic          avm_waitrequest = 1'b0;

    always #5 clk = ~clk;

    dnn_accel_system_hex_writer #(
        .NUM_DIGITS   (N),
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .BASE_ADDR    (16'h0),
        .DIGIT_STRIDE (STRIDE)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_value        (in_value),
        .in_decimal      (in_decimal),
        .in_lzb          (in_lzb),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write_n     (avm_write_n),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model of what each PIO currently displays
    logic [6:0] model_seg [N];
    bit         model_valid [N];

    logic [47:0] got_q [$];
    logic [47:0] exp_q [$];

    int stall_addr   = -1;
    int stall_left   = 0;
    bit rand_stall   = 1'b0;
    int stall_cycles = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave side: waitrequest policy, driven just after each active edge
    always @(posedge clk) begin
        #1;
        if (avm_chipselect && stall_left > 0 && int'(avm_address) == stall_addr) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end else if (avm_chipselect && rand_stall && $urandom_range(0, 2) == 0) begin
            avm_waitrequest = 1'b1;
        end else begin
            avm_waitrequest = 1'b0;
        end
        if (avm_chipselect && avm_waitrequest) stall_cycles++;
    end

    // Bus monitor: logs accepted writes and checks signals hold during stalls
    bit          stalled_prev = 1'b0;
    logic [AW-1:0] held_addr;
    logic [31:0] held_data;
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                chk("hold_cs", 32'(avm_chipselect), 32'd1);
                chk("hold_addr", 32'(avm_address), 32'(held_addr));
                chk("hold_data", avm_writedata, held_data);
            end
            if (avm_chipselect) chk("write_n_low", 32'(avm_write_n), 32'd0);
            stalled_prev = avm_chipselect && avm_waitrequest;
            held_addr    = avm_address;
            held_data    = avm_writedata;
            if (avm_chipselect && !avm_waitrequest)
                got_q.push_back({avm_address, avm_writedata});
        end
    end

    // Compute the expected writes for one update and advance the model
    task automatic model_update(input logic [DW-1:0] v, input bit dec, input bit lzb,
                                output bit d0_changed, output logic [6:0] p0);
        int d [N];
        int tmp;
        int hi;
        bit ovf;
        logic [6:0] p;
        ovf = dec && (v > 24'd999999);
        tmp = int'(v);
        for (int i = 0; i < N; i++) begin
            if (dec) begin
                d[i] = tmp % 10;
                tmp  = tmp / 10;
            end else begin
                d[i] = int'((v >> (4 * i)) & 24'hF);
            end
        end
        hi = -1;
        for (int i = 0; i < N; i++) if (d[i] != 0) hi = i;
        exp_q.delete();
        d0_changed = 1'b0;
        p0 = '0;
        for (int i = 0; i < N; i++) begin
            if (ovf)                         p = 7'h3F;
            else if (lzb && i > 0 && i > hi) p = 7'h7F;
            else                             p = lut[d[i]];
            if (!model_valid[i] || model_seg[i] != p) begin
                exp_q.push_back({16'(i * STRIDE), 25'b0, p});
                if (i == 0) begin
                    d0_changed = 1'b1;
                    p0 = p;
                end
            end
            model_seg[i]   = p;
            model_valid[i] = 1'b1;
        end
    endtask

    // One full update: handshake, timing of first write and ready, bus log
    task automatic send(input logic [DW-1:0] v, input bit dec, input bit lzb,
                        input bit noise, input string name);
        int c;
        int lat;
        int cap_lat;
        int exp_lat;
        bit d0_changed;
        logic [6:0] p0;
        logic first_cs;
        logic [AW-1:0] first_addr;
        logic [31:0] first_data;
        model_update(v, dec, lzb, d0_changed, p0);
        c = 0;
        while (!in_ready && c < 200) begin
            @(posedge clk); #1; c++;
        end
        chk({name, "_ready_before"}, 32'(in_ready), 32'd1);
        got_q.delete();
        stall_cycles = 0;
        in_value   = v;
        in_decimal = dec;
        in_lzb     = lzb;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        chk({name, "_ready_low"}, 32'(in_ready), 32'd0);
        in_value   = DW'($urandom());
        in_decimal = 1'($urandom());
        in_lzb     = 1'($urandom());
        in_valid   = noise;
        cap_lat    = (dec ? DW : 0) + 1;
        first_cs   = 1'b0;
        first_addr = '0;
        first_data = '0;
        lat = 0;
        while (!in_ready && lat < 400) begin
            @(posedge clk); #1; lat++;
            if (lat == cap_lat) begin
                first_cs   = avm_chipselect;
                first_addr = avm_address;
                first_data = avm_writedata;
            end
            in_valid = noise && lat < 3;
        end
        in_valid = 1'b0;
        exp_lat = (dec ? DW : 0) + N + 1 + stall_cycles;
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_first_cs"}, 32'(first_cs), 32'(d0_changed));
        if (d0_changed) begin
            chk({name, "_first_addr"}, 32'(first_addr), 32'd0);
            chk({name, "_first_data"}, first_data, {25'b0, p0});
        end
        chk({name, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({name, "_waddr"}, 32'(got_q[i][47:32]), 32'(exp_q[i][47:32]));
            chk({name, "_wdata"}, got_q[i][31:0], exp_q[i][31:0]);
        end
        $display("txn %s value=%06h dec=%0d lzb=%0d writes=%0d latency=%0d stalls=%0d",
                 name, v, dec, lzb, got_q.size(), lat, stall_cycles);
    endtask

    initial begin
        int c;
        int r;
        logic [DW-1:0] v;
        logic [DW-1:0] last_v;
        bit dec, lzb, last_dec, last_lzb;
        for (int i = 0; i < N; i++) begin
            model_valid[i] = 1'b0;
            model_seg[i]   = '0;
        end

        // Reset state
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_write_n", 32'(avm_write_n), 32'd1);
        chk("rst_addr", 32'(avm_address), 32'd0);
        chk("rst_data", avm_writedata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed scenarios
        send(24'h00BEEF, 1'b0, 1'b0, 1'b0, "hex_beef");
        send(24'd123456, 1'b1, 1'b0, 1'b0, "dec_123456");
        send(24'd1000000, 1'b1, 1'b1, 1'b0, "dec_overflow");
        send(24'd42, 1'b1, 1'b1, 1'b0, "dec_42_lzb");
        send(24'd42, 1'b1, 1'b1, 1'b0, "dec_42_resend");
        stall_addr = 32;
        stall_left = 3;
        send(24'h987654, 1'b0, 1'b0, 1'b1, "hex_stall_d2");
        chk("stall_count", 32'(stall_cycles), 32'd3);
        stall_addr = -1;
        stall_left = 0;

        // Reset while digit 3 is on the bus
        stall_addr = 48;
        stall_left = 50;
        c = 0;
        while (!in_ready && c < 200) begin
            @(posedge clk); #1; c++;
        end
        in_value   = 24'h13579B;
        in_decimal = 1'b0;
        in_lzb     = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        c = 0;
        while (!(avm_chipselect && avm_address == 16'd48) && c < 40) begin
            @(posedge clk); #1; c++;
        end
        chk("rst_mid_reached_d3", 32'(avm_chipselect && avm_address == 16'd48), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_cs", 32'(avm_chipselect), 32'd0);
        chk("rst_mid_write_n", 32'(avm_write_n), 32'd1);
        chk("rst_mid_ready", 32'(in_ready), 32'd0);
        stall_addr = -1;
        stall_left = 0;
        for (int i = 0; i < N; i++) model_valid[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        send(24'h13579B, 1'b0, 1'b0, 1'b0, "after_reset");

        // Randomized updates, with occasional repeats, overflows and stalls
        last_v = 24'h13579B;
        last_dec = 1'b0;
        last_lzb = 1'b0;
        for (int t = 0; t < 16; t++) begin
            r   = int'($urandom_range(0, 3));
            dec = 1'($urandom_range(0, 1));
            lzb = 1'($urandom_range(0, 1));
            case (r)
                0: begin v = last_v; dec = last_dec; lzb = last_lzb; end
                1: v = DW'($urandom_range(0, 999));
                2: begin v = DW'($urandom_range(1000000, 24'hFFFFFF)); dec = 1'b1; end
                default: v = DW'($urandom());
            endcase
            rand_stall = 1'($urandom_range(0, 1));
            send(v, dec, lzb, 1'($urandom_range(0, 1)), "rand");
            last_v = v;
            last_dec = dec;
            last_lzb = lzb;
        end
        rand_stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
